// File: rtl/sc_regbank_random_if.sv
// Bus bundle for the random register bank: debounced buttons, mode,
// read select and every observable output of the bank.
interface sc_regbank_random_if #(
    parameter int DATAWIDTH = 8,
    parameter int CHANNELS  = 4,
    parameter int SELW      = 2
);
    logic                 SC_REGBANK_clear_InLow;
    logic                 SC_REGBANK_load_InLow;
    logic                 SC_REGBANK_mode_In;
    logic [SELW-1:0]      SC_REGBANK_rdsel_InBUS;
    logic [DATAWIDTH-1:0] SC_REGBANK_data_OutBUS;
    logic [CHANNELS-1:0]  SC_REGBANK_valid_OutBUS;
    logic [SELW-1:0]      SC_REGBANK_wrptr_OutBUS;
    logic                 SC_REGBANK_full_Out;
    logic [DATAWIDTH-1:0] SC_REGBANK_random_OutBUS;

    // Board side: drives the buttons, mode and select, watches the bank.
    modport master (
        output SC_REGBANK_clear_InLow,
        output SC_REGBANK_load_InLow,
        output SC_REGBANK_mode_In,
        output SC_REGBANK_rdsel_InBUS,
        input  SC_REGBANK_data_OutBUS,
        input  SC_REGBANK_valid_OutBUS,
        input  SC_REGBANK_wrptr_OutBUS,
        input  SC_REGBANK_full_Out,
        input  SC_REGBANK_random_OutBUS
    );

    // Bank side.
    modport slave (
        input  SC_REGBANK_clear_InLow,
        input  SC_REGBANK_load_InLow,
        input  SC_REGBANK_mode_In,
        input  SC_REGBANK_rdsel_InBUS,
        output SC_REGBANK_data_OutBUS,
        output SC_REGBANK_valid_OutBUS,
        output SC_REGBANK_wrptr_OutBUS,
        output SC_REGBANK_full_Out,
        output SC_REGBANK_random_OutBUS
    );
endinterface

// File: rtl/sc_regbank_random.sv
// Multi-channel register bank filled in ring order from an internal
// Fibonacci LFSR. Writes come from a load press or a periodic auto capture;
// a clear press wipes the bank. One channel is read back, registered.
module sc_regbank_random #(
    parameter int                   DATAWIDTH   = 8,
    parameter int                   CHANNELS    = 4,
    parameter int                   SELW        = 2,
    parameter logic [DATAWIDTH-1:0] LFSR_SEED   = 8'hA5,
    parameter logic [DATAWIDTH-1:0] LFSR_TAPS   = 8'hB8,
    parameter int                   AUTO_PERIOD = 16
) (
    input logic                 SC_REGBANK_CLOCK_50,
    input logic                 SC_REGBANK_RESET_InHigh,
    sc_regbank_random_if.slave  bus
);
    localparam int CNTW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_HOLD,
        CLEAR_HOLD
    } state_t;

    logic clk;
    logic rst;
    assign clk = SC_REGBANK_CLOCK_50;
    assign rst = SC_REGBANK_RESET_InHigh;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] lfsr_q, lfsr_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] bank_q [CHANNELS];
    logic [DATAWIDTH-1:0] bank_d [CHANNELS];
    logic [CHANNELS-1:0]  valid_q, valid_d;
    logic [SELW-1:0]      wrptr_q, wrptr_d;
    logic                 full_q, full_d;
    logic [DATAWIDTH-1:0] data_q, data_d;

    logic ld_pulse;
    logic clr_pulse;
    logic auto_tick;
    logic wr;
    logic fb;

    // Press FSM: one pulse per press; the pulse is decoded from IDLE and the
    // button so the write lands on the same edge the press is first seen.
    always_comb begin
        state_d   = state_q;
        ld_pulse  = 1'b0;
        clr_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.SC_REGBANK_clear_InLow) begin
                    state_d   = CLEAR_HOLD;
                    clr_pulse = 1'b1;
                end else if (!bus.SC_REGBANK_load_InLow) begin
                    state_d  = LOAD_HOLD;
                    ld_pulse = 1'b1;
                end
            end
            LOAD_HOLD: begin
                if (bus.SC_REGBANK_load_InLow) begin
                    state_d = IDLE;
                end
            end
            CLEAR_HOLD: begin
                if (bus.SC_REGBANK_clear_InLow) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // LFSR step; a zero state can never advance on its own, so reseed it.
    always_comb begin
        fb = ^(lfsr_q & LFSR_TAPS);
        if (lfsr_q == '0) begin
            lfsr_d = LFSR_SEED;
        end else begin
            lfsr_d = {lfsr_q[DATAWIDTH-2:0], fb};
        end
    end

    // Auto-capture counter: free-runs modulo AUTO_PERIOD only in auto mode.
    always_comb begin
        auto_tick = bus.SC_REGBANK_mode_In && (cnt_q == CNT_LAST);
        if (!bus.SC_REGBANK_mode_In) begin
            cnt_d = '0;
        end else if (auto_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    // Bank update: clear beats any write; a coincident press and tick still
    // make a single write and a single pointer step.
    always_comb begin
        bank_d  = bank_q;
        valid_d = valid_q;
        wrptr_d = wrptr_q;
        wr      = (ld_pulse || auto_tick) && !clr_pulse;
        if (clr_pulse) begin
            for (int i = 0; i < CHANNELS; i++) begin
                bank_d[i] = '0;
            end
            valid_d = '0;
            wrptr_d = '0;
        end else if (wr) begin
            bank_d[wrptr_q]  = lfsr_q;
            valid_d[wrptr_q] = 1'b1;
            wrptr_d          = wrptr_q + SELW'(1);
        end
        full_d = &valid_d;
        data_d = bank_q[bus.SC_REGBANK_rdsel_InBUS];
    end

    // All state registers, with a synchronous reset that overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                bank_q[i] <= '0;
            end
            valid_q <= '0;
            wrptr_q <= '0;
            full_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            valid_q <= valid_d;
            wrptr_q <= wrptr_d;
            full_q  <= full_d;
            data_q  <= data_d;
        end
    end

    assign bus.SC_REGBANK_data_OutBUS   = data_q;
    assign bus.SC_REGBANK_valid_OutBUS  = valid_q;
    assign bus.SC_REGBANK_wrptr_OutBUS  = wrptr_q;
    assign bus.SC_REGBANK_full_Out      = full_q;
    assign bus.SC_REGBANK_random_OutBUS = lfsr_q;
endmodule

// File: tb/tb_sc_regbank_random.sv
// Directed bench for sc_regbank_random: a vector table for the press,
// overwrite and clear behaviour plus hand sequences for auto capture and
// reset during a held load.
module tb_sc_regbank_random;
    logic clk;
    logic rst;

    int checks;
    int errors;

    typedef struct {
        logic       rst;
        logic       clrN;
        logic       ldN;
        logic       mode;
        logic [1:0] rdsel;
        logic [7:0] expRandom;
        logic [7:0] expData;
        logic [3:0] expValid;
        logic [1:0] expWrptr;
        logic       expFull;
    } vec_t;

    vec_t vecs[$];

    sc_regbank_random_if #(.DATAWIDTH(8), .CHANNELS(4), .SELW(2)) bus ();

    sc_regbank_random #(
        .DATAWIDTH(8),
        .CHANNELS(4),
        .SELW(2),
        .LFSR_SEED(8'hA5),
        .LFSR_TAPS(8'hB8),
        .AUTO_PERIOD(16)
    ) dut (
        .SC_REGBANK_CLOCK_50(clk),
        .SC_REGBANK_RESET_InHigh(rst),
        .bus(bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Pre-edge LFSR value seen at the n-th edge after reset (n >= 1).
    function automatic logic [7:0] lfsrAt(input int n);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 1; i < n; i++) begin
            v = {v[6:0], ^(v & 8'hB8)};
        end
        return v;
    endfunction

    // Drive inputs at the falling edge and run n rising edges.
    task automatic applyStimulus(input logic r, input logic clrN, input logic ldN,
                                 input logic mode, input logic [1:0] rdsel, input int n);
        rst = r;
        bus.SC_REGBANK_clear_InLow = clrN;
        bus.SC_REGBANK_load_InLow  = ldN;
        bus.SC_REGBANK_mode_In     = mode;
        bus.SC_REGBANK_rdsel_InBUS = rdsel;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // One comparison.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic r, input logic clrN, input logic ldN, input logic mode,
                          input logic [1:0] rdsel, input logic [7:0] eRnd, input logic [7:0] eData,
                          input logic [3:0] eValid, input logic [1:0] eWp, input logic eFull);
        vec_t v;
        v.rst = r; v.clrN = clrN; v.ldN = ldN; v.mode = mode; v.rdsel = rdsel;
        v.expRandom = eRnd; v.expData = eData; v.expValid = eValid;
        v.expWrptr = eWp; v.expFull = eFull;
        vecs.push_back(v);
    endtask

    task automatic checkAll(input string tag, input logic [7:0] eRnd, input logic [7:0] eData,
                            input logic [3:0] eValid, input logic [1:0] eWp, input logic eFull);
        checkOutput({tag, " random"}, 32'(bus.SC_REGBANK_random_OutBUS), 32'(eRnd));
        checkOutput({tag, " data"},   32'(bus.SC_REGBANK_data_OutBUS),   32'(eData));
        checkOutput({tag, " valid"},  32'(bus.SC_REGBANK_valid_OutBUS),  32'(eValid));
        checkOutput({tag, " wrptr"},  32'(bus.SC_REGBANK_wrptr_OutBUS),  32'(eWp));
        checkOutput({tag, " full"},   32'(bus.SC_REGBANK_full_Out),      32'(eFull));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.SC_REGBANK_clear_InLow = 1'b1;
        bus.SC_REGBANK_load_InLow  = 1'b1;
        bus.SC_REGBANK_mode_In     = 1'b0;
        bus.SC_REGBANK_rdsel_InBUS = 2'd0;

        //      rst clr ld  md sel rand   data   valid    wp  full
        // reset, then free-running LFSR
        addVec(1, 1, 1, 0, 0, 8'hA5, 8'h00, 4'b0000, 0, 0);
        addVec(1, 1, 1, 0, 0, 8'hA5, 8'h00, 4'b0000, 0, 0);
        addVec(0, 1, 1, 0, 0, 8'h4A, 8'h00, 4'b0000, 0, 0);
        addVec(0, 1, 1, 0, 0, 8'h95, 8'h00, 4'b0000, 0, 0);
        addVec(0, 1, 1, 0, 0, 8'h2A, 8'h00, 4'b0000, 0, 0);
        // reset, then load held for 10 cycles: one write of A5
        addVec(1, 1, 1, 0, 0, 8'hA5, 8'h00, 4'b0000, 0, 0);
        addVec(0, 1, 0, 0, 0, 8'h4A, 8'h00, 4'b0001, 1, 0);
        addVec(0, 1, 0, 0, 0, 8'h95, 8'hA5, 4'b0001, 1, 0);
        addVec(0, 1, 0, 0, 0, 8'h2A, 8'hA5, 4'b0001, 1, 0);
        addVec(0, 1, 0, 0, 0, 8'h54, 8'hA5, 4'b0001, 1, 0);
        addVec(0, 1, 0, 0, 0, 8'hA9, 8'hA5, 4'b0001, 1, 0);
        addVec(0, 1, 0, 0, 0, 8'h53, 8'hA5, 4'b0001, 1, 0);
        addVec(0, 1, 0, 0, 0, 8'hA7, 8'hA5, 4'b0001, 1, 0);
        addVec(0, 1, 0, 0, 0, 8'h4E, 8'hA5, 4'b0001, 1, 0);
        addVec(0, 1, 0, 0, 0, 8'h9D, 8'hA5, 4'b0001, 1, 0);
        addVec(0, 1, 0, 0, 0, 8'h3B, 8'hA5, 4'b0001, 1, 0);
        addVec(0, 1, 1, 0, 0, 8'h77, 8'hA5, 4'b0001, 1, 0);
        addVec(0, 1, 1, 0, 0, 8'hEE, 8'hA5, 4'b0001, 1, 0);
        // further presses fill the bank; fifth press overwrites channel 0
        addVec(0, 1, 0, 0, 0, 8'hDD, 8'hA5, 4'b0011, 2, 0);
        addVec(0, 1, 1, 0, 0, 8'hBB, 8'hA5, 4'b0011, 2, 0);
        addVec(0, 1, 0, 0, 0, 8'h76, 8'hA5, 4'b0111, 3, 0);
        addVec(0, 1, 1, 0, 0, 8'hEC, 8'hA5, 4'b0111, 3, 0);
        addVec(0, 1, 0, 0, 0, 8'hD9, 8'hA5, 4'b1111, 0, 1);
        addVec(0, 1, 1, 0, 0, 8'hB3, 8'hA5, 4'b1111, 0, 1);
        addVec(0, 1, 0, 0, 0, 8'h67, 8'hA5, 4'b1111, 1, 1);
        addVec(0, 1, 1, 0, 0, 8'hCF, 8'hB3, 4'b1111, 1, 1);
        addVec(0, 1, 1, 0, 1, 8'h9E, 8'hEE, 4'b1111, 1, 1);
        addVec(0, 1, 1, 0, 2, 8'h3D, 8'hBB, 4'b1111, 1, 1);
        addVec(0, 1, 1, 0, 3, 8'h7B, 8'hEC, 4'b1111, 1, 1);
        // clear and load together on a full bank: clear wins, no write
        addVec(0, 0, 0, 0, 3, 8'hF7, 8'hEC, 4'b0000, 0, 0);
        addVec(0, 0, 0, 0, 3, 8'hEF, 8'h00, 4'b0000, 0, 0);
        addVec(0, 1, 0, 0, 3, 8'hDF, 8'h00, 4'b0000, 0, 0);
        addVec(0, 1, 0, 0, 3, 8'hBF, 8'h00, 4'b0001, 1, 0);
        addVec(0, 1, 1, 0, 0, 8'h7E, 8'hDF, 4'b0001, 1, 0);
        // clear pressed during LOAD_HOLD is ignored until IDLE
        addVec(0, 1, 0, 0, 0, 8'hFD, 8'hDF, 4'b0011, 2, 0);
        addVec(0, 0, 0, 0, 0, 8'hFA, 8'hDF, 4'b0011, 2, 0);
        addVec(0, 0, 1, 0, 0, 8'hF4, 8'hDF, 4'b0011, 2, 0);
        addVec(0, 0, 1, 0, 0, 8'hE9, 8'hDF, 4'b0000, 0, 0);
        addVec(0, 1, 1, 0, 0, 8'hD3, 8'h00, 4'b0000, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].clrN, vecs[i].ldN, vecs[i].mode, vecs[i].rdsel, 1);
            checkAll($sformatf("vec%0d", i), vecs[i].expRandom, vecs[i].expData,
                     vecs[i].expValid, vecs[i].expWrptr, vecs[i].expFull);
        end

        // Auto capture: ticks at edges 16, 32, 48, 64 after reset.
        applyStimulus(1, 1, 1, 0, 0, 2);
        applyStimulus(0, 1, 1, 1, 0, 15);
        checkOutput("auto e15 wrptr", 32'(bus.SC_REGBANK_wrptr_OutBUS), 32'd0);
        checkOutput("auto e15 random", 32'(bus.SC_REGBANK_random_OutBUS), 32'(lfsrAt(16)));
        applyStimulus(0, 1, 1, 1, 0, 1);
        checkOutput("auto e16 wrptr", 32'(bus.SC_REGBANK_wrptr_OutBUS), 32'd1);
        checkOutput("auto e16 valid", 32'(bus.SC_REGBANK_valid_OutBUS), 32'h1);
        applyStimulus(0, 1, 1, 1, 0, 16);
        checkOutput("auto e32 valid", 32'(bus.SC_REGBANK_valid_OutBUS), 32'h3);
        applyStimulus(0, 1, 1, 1, 0, 16);
        checkOutput("auto e48 wrptr", 32'(bus.SC_REGBANK_wrptr_OutBUS), 32'd3);
        checkOutput("auto e48 valid", 32'(bus.SC_REGBANK_valid_OutBUS), 32'h7);
        applyStimulus(0, 1, 1, 1, 0, 15);
        checkOutput("auto ch0", 32'(bus.SC_REGBANK_data_OutBUS), 32'(lfsrAt(16)));
        checkOutput("auto e63 wrptr", 32'(bus.SC_REGBANK_wrptr_OutBUS), 32'd3);
        // load press coincides with the tick at edge 64: single advance
        applyStimulus(0, 1, 0, 1, 0, 1);
        checkOutput("tick+load wrptr", 32'(bus.SC_REGBANK_wrptr_OutBUS), 32'd0);
        checkOutput("tick+load valid", 32'(bus.SC_REGBANK_valid_OutBUS), 32'hF);
        checkOutput("tick+load full", 32'(bus.SC_REGBANK_full_Out), 32'd1);
        applyStimulus(0, 1, 1, 1, 3, 1);
        checkOutput("auto ch3", 32'(bus.SC_REGBANK_data_OutBUS), 32'(lfsrAt(64)));
        applyStimulus(0, 1, 1, 1, 1, 1);
        checkOutput("auto ch1", 32'(bus.SC_REGBANK_data_OutBUS), 32'(lfsrAt(32)));
        applyStimulus(0, 1, 1, 1, 2, 1);
        checkOutput("auto ch2", 32'(bus.SC_REGBANK_data_OutBUS), 32'(lfsrAt(48)));
        // mode drop mid-count restarts the period from zero
        applyStimulus(0, 1, 1, 1, 0, 2);
        applyStimulus(0, 1, 1, 0, 0, 3);
        applyStimulus(0, 1, 1, 1, 0, 15);
        checkOutput("restart e15 wrptr", 32'(bus.SC_REGBANK_wrptr_OutBUS), 32'd0);
        applyStimulus(0, 1, 1, 1, 0, 1);
        checkOutput("restart e16 wrptr", 32'(bus.SC_REGBANK_wrptr_OutBUS), 32'd1);
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("restart ch0", 32'(bus.SC_REGBANK_data_OutBUS), 32'(lfsrAt(88)));
        checkOutput("restart random", 32'(bus.SC_REGBANK_random_OutBUS), 32'(lfsrAt(90)));

        // Reset during LOAD_HOLD with load still held.
        applyStimulus(1, 1, 1, 0, 0, 2);
        applyStimulus(0, 1, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 2);
        checkOutput("pre-reset valid", 32'(bus.SC_REGBANK_valid_OutBUS), 32'h3);
        applyStimulus(1, 1, 0, 0, 0, 1);
        checkAll("hold reset", 8'hA5, 8'h00, 4'b0000, 2'd0, 1'b0);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkAll("hold post1", 8'h4A, 8'h00, 4'b0001, 2'd1, 1'b0);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkAll("hold post2", 8'h95, 8'hA5, 4'b0001, 2'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sc_regbank_random.md
Name: sc_regbank_random

Overview:
- Parametrised successor of the single general register fed by a shifter random source.
- Holds CHANNELS registers of DATAWIDTH bits, written in ring order from an internal LFSR.
- Writes come from manual load presses or from an automatic periodic capture mode. A clear press wipes the whole bank.
- Sits behind the debounce stage in the board system. It replaces the separate state machine, shifter and general register. One channel is selected for display.

Parameters:
- DATAWIDTH, 8: width of each channel and of the LFSR.
- CHANNELS, 4: number of bank registers; must be 2 or more, power of 2.
- SELW, 2: select/pointer width; equals log2(CHANNELS).
- LFSR_SEED, 8'hA5: LFSR reset value; must be non-zero.
- LFSR_TAPS, 8'hB8: feedback tap mask; bit i set means state bit i is in the XOR.
- AUTO_PERIOD, 16: cycles between automatic captures; must be 2 or more.

Ports:
- SC_REGBANK_CLOCK_50, in, 1: single system clock; all state changes on its rising edge.
- SC_REGBANK_RESET_InHigh, in, 1: synchronous, active-high reset.
- SC_REGBANK_clear_InLow, in, 1: debounced clear button, active low.
- SC_REGBANK_load_InLow, in, 1: debounced load button, active low.
- SC_REGBANK_mode_In, in, 1: 0 = manual, 1 = auto capture.
- SC_REGBANK_rdsel_InBUS, in, SELW: channel shown on data_OutBUS.
- SC_REGBANK_data_OutBUS, out, DATAWIDTH: registered contents of the selected channel.
- SC_REGBANK_valid_OutBUS, out, CHANNELS: bit i = 1 when channel i has been written since the last clear or reset.
- SC_REGBANK_wrptr_OutBUS, out, SELW: next channel to be written.
- SC_REGBANK_full_Out, out, 1: 1 when every valid bit is set.
- SC_REGBANK_random_OutBUS, out, DATAWIDTH: current LFSR state.

Behaviour:
- Reset (synchronous, high):
  - All channels, data_OutBUS, valid_OutBUS, wrptr_OutBUS and full_Out go to 0.
  - LFSR goes to LFSR_SEED; auto counter goes to 0; FSM goes to IDLE.
  - Reset overrides every other input in the same cycle.
- LFSR:
  - Advances every non-reset cycle: next = {state[DATAWIDTH-2:0], fb}.
  - fb = XOR of (state AND LFSR_TAPS).
  - If the state is ever 0, the next state is LFSR_SEED.
- Press FSM, states IDLE, LOAD_HOLD, CLEAR_HOLD:
  - IDLE with clear low: go to CLEAR_HOLD and assert clr_pulse for that one cycle. Clear has priority when both buttons are low.
  - IDLE with load low (clear high): go to LOAD_HOLD and assert ld_pulse for that one cycle.
  - LOAD_HOLD: stay while load is low. Return to IDLE on load high. A clear pressed during LOAD_HOLD is ignored until IDLE is reached.
  - CLEAR_HOLD: stay while clear is low. Return to IDLE on clear high.
  - A held button produces exactly one pulse.
- Auto counter:
  - Held at 0 while mode = 0.
  - While mode = 1 it counts 0..AUTO_PERIOD-1 and wraps.
  - auto_tick = 1 in the cycle where mode = 1 and count = AUTO_PERIOD-1.
  - A 1 to 0 change of mode zeroes the counter on the next edge.
- Write:
  - wr = ld_pulse OR auto_tick, with clr_pulse absent.
  - On wr: channel[wrptr] <= current random_OutBUS (the pre-edge LFSR value); valid[wrptr] <= 1; wrptr <= wrptr+1 mod CHANNELS.
  - ld_pulse and auto_tick in the same cycle give one write and one pointer advance.
  - When full, writes continue in ring order, overwriting the oldest channel; full_Out stays 1.
- Clear:
  - On clr_pulse, all channels, valid bits and wrptr go to 0 at that edge.
  - Any simultaneous write is dropped.
  - The auto counter is unaffected.
- Read:
  - data_OutBUS <= channel[rdsel] using pre-edge bank contents, so latency is 1 cycle from a rdsel change.
  - A write at edge k is visible at the output after edge k+1.
- full_Out is registered: it equals the AND of the valid bits after each edge.

Test Plan:
- Reset then observe the LFSR -> random_OutBUS reads 0xA5, 0x4A, 0x95 on successive cycles; all other outputs are 0.
- Load held low for 10 cycles starting with the first cycle after reset -> channel0 = 0xA5, valid = 0001, wrptr = 1. Exactly one write occurs; on release the FSM returns to IDLE.
- Five separate load presses -> valid = 1111 and full_Out = 1 after the fourth press. The fifth press overwrites channel0; wrptr = 1.
- Clear and load fall low in the same cycle with bank full -> all channels 0, valid = 0000, wrptr = 0, full_Out = 0, no write.
- mode = 1 for 48 cycles with no buttons -> 3 writes, at counts 15, 31 and 47. A load press on the same cycle as an auto_tick -> a single pointer advance.
- Reset asserted during LOAD_HOLD with the bank partly written -> everything returns to reset values. With load still held, the FSM sees low in IDLE after reset release and writes 0xA5 once.
